// File: rtl/hist_cdf_sequencer.sv
// hist_cdf_sequencer
// Frame-level controller for the histogram block. Delays frame_done, issues
// end_of_frame, waits for the copy-complete pulse, then sweeps every bin of
// the output RAM and streams a running sum (CDF). Between frames the same
// read port serves single-bin host reads.
module hist_cdf_sequencer #(
    parameter int BINS         = 256,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int CDF_W        = 24,
    parameter int EOF_DELAY    = 4,
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done,
    output logic              hist_end_of_frame,
    input  logic              hist_out_valid,
    output logic [ADDR_W-1:0] hist_addr,
    input  logic [DATA_W-1:0] hist_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    output logic              cdf_valid,
    output logic [ADDR_W-1:0] cdf_bin,
    output logic [CDF_W-1:0]  cdf_value,
    output logic              cdf_last,
    output logic              busy,
    output logic              overflow,
    output logic              timeout
);

    // One shared counter covers the EOF delay, the wait timeout, the sweep
    // address (needs one extra bit to hold BINS) and the drain.
    localparam int CNT_LIM = (WAIT_TIMEOUT > BINS) ? WAIT_TIMEOUT : BINS;
    localparam int CNT_MAX = (CNT_LIM > EOF_DELAY) ? CNT_LIM : EOF_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HOST_RD,
        EOF_DLY,
        WAIT_HIST,
        SWEEP,
        DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              pending_reg, pending_next;
    logic              overflow_reg, overflow_next;
    logic              timeout_reg, timeout_next;
    logic              eof_reg, eof_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] host_data_reg, host_data_next;
    logic              ack_reg, ack_next;
    // Read pipeline: stage 1 = address registered, stage 2 = BRAM sampled it.
    logic              rd_v1_reg, rd_v1_next;
    logic              rd_v2_reg, rd_v2_next;
    logic [ADDR_W-1:0] bin2_reg, bin2_next;
    logic [CDF_W-1:0]  acc_reg, acc_next;
    logic              cdf_valid_reg, cdf_valid_next;
    logic [ADDR_W-1:0] cdf_bin_reg, cdf_bin_next;
    logic [CDF_W-1:0]  cdf_value_reg, cdf_value_next;
    logic              cdf_last_reg, cdf_last_next;
    logic [CDF_W-1:0]  sum;

    assign busy = (state_reg != IDLE) && (state_reg != HOST_RD);

    // State and datapath registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pending_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            eof_reg       <= 1'b0;
            addr_reg      <= '0;
            host_data_reg <= '0;
            ack_reg       <= 1'b0;
            rd_v1_reg     <= 1'b0;
            rd_v2_reg     <= 1'b0;
            bin2_reg      <= '0;
            acc_reg       <= '0;
            cdf_valid_reg <= 1'b0;
            cdf_bin_reg   <= '0;
            cdf_value_reg <= '0;
            cdf_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pending_reg   <= pending_next;
            overflow_reg  <= overflow_next;
            timeout_reg   <= timeout_next;
            eof_reg       <= eof_next;
            addr_reg      <= addr_next;
            host_data_reg <= host_data_next;
            ack_reg       <= ack_next;
            rd_v1_reg     <= rd_v1_next;
            rd_v2_reg     <= rd_v2_next;
            bin2_reg      <= bin2_next;
            acc_reg       <= acc_next;
            cdf_valid_reg <= cdf_valid_next;
            cdf_bin_reg   <= cdf_bin_next;
            cdf_value_reg <= cdf_value_next;
            cdf_last_reg  <= cdf_last_next;
        end
    end

    // Next-state, read pipeline and CDF accumulation.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pending_next   = pending_reg;
        overflow_next  = overflow_reg;
        timeout_next   = timeout_reg;
        eof_next       = 1'b0;
        addr_next      = addr_reg;
        host_data_next = host_data_reg;
        ack_next       = 1'b0;
        rd_v1_next     = 1'b0;
        rd_v2_next     = rd_v1_reg;
        bin2_next      = addr_reg;
        acc_next       = acc_reg;
        cdf_valid_next = rd_v2_reg;
        cdf_bin_next   = cdf_bin_reg;
        cdf_value_next = cdf_value_reg;
        cdf_last_next  = 1'b0;
        sum            = acc_reg + CDF_W'(hist_data);

        // Stage 2 of the read pipeline: RAM data is valid for this edge.
        if (rd_v2_reg) begin
            cdf_bin_next   = bin2_reg;
            cdf_value_next = sum;
            cdf_last_next  = (bin2_reg == ADDR_W'(BINS - 1));
            acc_next       = sum;
        end

        // Frames that land while one is in flight are dropped and flagged.
        if (frame_done && busy) begin
            overflow_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (frame_done || pending_reg) begin
                    if (frame_done && pending_reg) begin
                        overflow_next = 1'b1;
                    end
                    pending_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = EOF_DLY;
                end else if (host_req && !ack_reg) begin
                    // Address goes out on this edge; ack two edges later.
                    addr_next  = host_addr;
                    cnt_next   = '0;
                    state_next = HOST_RD;
                end
            end
            HOST_RD: begin
                if (frame_done) begin
                    if (pending_reg) begin
                        overflow_next = 1'b1;
                    end
                    pending_next = 1'b1;
                end
                if (cnt_reg == CNT_W'(1)) begin
                    host_data_next = hist_data;
                    ack_next       = 1'b1;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            EOF_DLY: begin
                if (cnt_reg == CNT_W'(EOF_DELAY)) begin
                    eof_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT_HIST;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_HIST: begin
                if (hist_out_valid) begin
                    cnt_next   = '0;
                    acc_next   = '0;
                    state_next = SWEEP;
                end else if (cnt_reg == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SWEEP: begin
                if (cnt_reg == CNT_W'(BINS)) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    addr_next  = cnt_reg[ADDR_W-1:0];
                    rd_v1_next = 1'b1;
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hist_end_of_frame = eof_reg;
    assign hist_addr         = addr_reg;
    assign host_data         = host_data_reg;
    assign host_ack          = ack_reg;
    assign cdf_valid         = cdf_valid_reg;
    assign cdf_bin           = cdf_bin_reg;
    assign cdf_value         = cdf_value_reg;
    assign cdf_last          = cdf_last_reg;
    assign overflow          = overflow_reg;
    assign timeout           = timeout_reg;

endmodule

// File: tb/tb_hist_cdf_sequencer.sv
// Testbench for hist_cdf_sequencer: models the histogram output RAM with a
// registered read and checks frame sequencing, the CDF stream, host reads,
// overlap errors, timeout and asynchronous reset.
module tb_hist_cdf_sequencer;

    localparam int BINS         = 256;
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 16;
    localparam int CDF_W        = 24;
    localparam int EOF_DELAY    = 4;
    localparam int WAIT_TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_done = 1'b0;
    logic              hist_end_of_frame;
    logic              hist_out_valid = 1'b0;
    logic [ADDR_W-1:0] hist_addr;
    logic [DATA_W-1:0] hist_data;
    logic              host_req = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_data;
    logic              host_ack;
    logic              cdf_valid;
    logic [ADDR_W-1:0] cdf_bin;
    logic [CDF_W-1:0]  cdf_value;
    logic              cdf_last;
    logic              busy;
    logic              overflow;
    logic              timeout;

    logic [DATA_W-1:0] mem [0:BINS-1];
    int tests_run    = 0;
    int tests_failed = 0;
    int ack_total    = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] exp_data;
    } host_vec_t;

    host_vec_t vecs [4];

    hist_cdf_sequencer #(
        .BINS(BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CDF_W(CDF_W),
        .EOF_DELAY(EOF_DELAY), .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done),
        .hist_end_of_frame(hist_end_of_frame), .hist_out_valid(hist_out_valid),
        .hist_addr(hist_addr), .hist_data(hist_data),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .cdf_valid(cdf_valid), .cdf_bin(cdf_bin),
        .cdf_value(cdf_value), .cdf_last(cdf_last), .busy(busy),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Histogram output RAM: registered read of the sequencer's address.
    always @(posedge clk) hist_data <= mem[hist_addr];

    always @(negedge clk) if (host_ack === 1'b1) ack_total++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_eof(input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound && k < 0; i++) begin
            @(negedge clk);
            if (hist_end_of_frame) k = i;
        end
    endtask

    task automatic start_frame(input string tag);
        int k;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        wait_eof(20, k);
        check({tag, " eof latency"}, k, EOF_DELAY + 1);
        @(negedge clk);
        check({tag, " eof width"}, hist_end_of_frame, 0);
        $display("[TB] %s: frame_done -> end_of_frame after %0d cycles", tag, k);
    endtask

    task automatic give_valid(input string tag);
        repeat (3) @(negedge clk);
        hist_out_valid = 1'b1;
        @(negedge clk);
        hist_out_valid = 1'b0;
        @(negedge clk);
        check({tag, " first addr"}, hist_addr, 0);
        check({tag, " busy in sweep"}, busy, 1);
    endtask

    task automatic collect(input string tag, input int exp_last, input int ovf_bin);
        int cnt, first, gaps;
        bit done;
        logic [CDF_W-1:0] run;
        cnt = 0; first = -1; gaps = 0; done = 1'b0; run = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            frame_done = 1'b0;
            if (cdf_valid) begin
                if (first < 0) first = i;
                run = run + CDF_W'(mem[cnt[ADDR_W-1:0]]);
                check({tag, " cdf_bin"}, cdf_bin, cnt);
                check({tag, " cdf_value"}, cdf_value, run);
                check({tag, " cdf_last"}, cdf_last, (cnt == BINS - 1));
                if (cdf_last) begin
                    done = 1'b1;
                    check({tag, " busy at last"}, busy, 1);
                    if (exp_last >= 0) check({tag, " last value"}, cdf_value, exp_last);
                end
                if (cnt == ovf_bin) frame_done = 1'b1;
                cnt++;
            end else if (first >= 0) begin
                gaps++;
            end
        end
        check({tag, " cdf latency"}, first, 1);
        check({tag, " cdf gaps"}, gaps, 0);
        check({tag, " cdf count"}, cnt, BINS);
        @(negedge clk);
        check({tag, " valid after last"}, cdf_valid, 0);
        check({tag, " busy after last"}, busy, 0);
        $display("[TB] %s: %0d cdf words, final value %0d", tag, cnt, run);
    endtask

    task automatic host_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        int k, extra;
        host_addr = a;
        host_req  = 1'b1;
        k = -1;
        for (int i = 1; i <= 10 && k < 0; i++) begin
            @(negedge clk);
            if (host_ack) k = i;
        end
        check({tag, " ack latency"}, k, 3);
        check({tag, " host_data"}, host_data, exp);
        @(negedge clk);
        host_req = 1'b0;
        check({tag, " ack width"}, host_ack, 0);
        check({tag, " data held"}, host_data, exp);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (host_ack) extra++;
        end
        check({tag, " no re-read"}, extra, 0);
        $display("[TB] %s: addr 0x%02h -> data 0x%04h after %0d edges", tag, a, host_data, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acks_before, extra, found;

        vecs[0] = '{addr: 8'h2A, stored: 16'h1234, exp_data: 16'h1234};
        vecs[1] = '{addr: 8'h00, stored: 16'h0001, exp_data: 16'h0001};
        vecs[2] = '{addr: 8'hFF, stored: 16'hFFFF, exp_data: 16'hFFFF};
        vecs[3] = '{addr: 8'h80, stored: 16'hA5A5, exp_data: 16'hA5A5};
        for (int i = 0; i < BINS; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset cdf_valid", cdf_valid, 0);
        check("reset hist_addr", hist_addr, 0);
        check("reset eof", hist_end_of_frame, 0);
        check("reset flags", {overflow, timeout, host_ack}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Host reads from the vector table
        for (int i = 0; i < 4; i++) mem[vecs[i].addr] = vecs[i].stored;
        for (int i = 0; i < 4; i++) host_read($sformatf("host vec %0d", i), vecs[i].addr, vecs[i].exp_data);

        // Uniform frame
        for (int i = 0; i < BINS; i++) mem[i] = 16'd1;
        start_frame("uniform");
        give_valid("uniform");
        collect("uniform", 256, -1);

        // Full-scale frame
        for (int i = 0; i < BINS; i++) mem[i] = '0;
        mem[0] = 16'hFFFF;
        mem[BINS-1] = 16'hFFFF;
        start_frame("fullscale");
        give_valid("fullscale");
        collect("fullscale", 131070, -1);

        // Same-cycle frame_done and host_req: frame first, host after sweep
        mem[8'h2A] = 16'h1234;
        acks_before = ack_total;
        host_addr  = 8'h2A;
        host_req   = 1'b1;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        wait_eof(20, k);
        check("tie eof latency", k, EOF_DELAY + 1);
        give_valid("tie");
        collect("tie", -1, -1);
        check("tie no early ack", ack_total - acks_before, 0);
        k = -1;
        for (int i = 1; i <= 10 && k < 0; i++) begin
            @(negedge clk);
            if (host_ack) k = i;
        end
        check("tie ack latency", k, 3);
        check("tie host_data", host_data, 16'h1234);
        @(negedge clk);
        host_req = 1'b0;
        $display("[TB] tie: host ack %0d edges after sweep end", k);

        // frame_done during HOST_RD is deferred, not an overflow
        mem[8'h80] = 16'hA5A5;
        host_addr = 8'h80;
        host_req  = 1'b1;
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        @(negedge clk);
        check("hostrd ack", host_ack, 1);
        check("hostrd data", host_data, 16'hA5A5);
        @(negedge clk);
        host_req = 1'b0;
        wait_eof(20, k);
        check("hostrd pending eof", k, EOF_DELAY + 1);
        check("hostrd overflow", overflow, 0);
        give_valid("hostrd frame");
        collect("hostrd frame", -1, -1);

        // frame_done during SWEEP: overflow, exactly one stream
        for (int i = 0; i < BINS; i++) mem[i] = DATA_W'(i);
        start_frame("ovf");
        give_valid("ovf");
        collect("ovf", 32640, 100);
        check("ovf flag", overflow, 1);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (hist_end_of_frame || cdf_valid) extra++;
        end
        check("ovf no second frame", extra, 0);
        $display("[TB] ovf: overflow=%0d", overflow);

        // Timeout: hist_out_valid withheld
        start_frame("timeout");
        extra = 0;
        repeat (WAIT_TIMEOUT - 2) begin
            @(negedge clk);
            if (cdf_valid) extra++;
        end
        check("timeout early", timeout, 0);
        check("timeout busy before", busy, 1);
        @(negedge clk);
        check("timeout flag", timeout, 1);
        check("timeout idle", busy, 0);
        check("timeout no cdf", extra, 0);
        $display("[TB] timeout: timeout=%0d busy=%0d", timeout, busy);

        // Asynchronous reset in the middle of a sweep
        for (int i = 0; i < BINS; i++) mem[i] = DATA_W'(3 * i);
        start_frame("rst");
        give_valid("rst");
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (cdf_valid && cdf_bin == 8'd100) found = 1;
        end
        check("rst reached bin 100", found, 1);
        rst = 1'b0;
        #1;
        check("rst cdf outputs", {cdf_valid, cdf_last, cdf_bin, cdf_value}, 0);
        check("rst host outputs", {host_ack, host_data, hist_addr, hist_end_of_frame}, 0);
        check("rst flags", {busy, overflow, timeout}, 0);
        $display("[TB] rst: outputs cleared at bin 100");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_frame("after rst");
        give_valid("after rst");
        collect("after rst", 97920, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
